mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port data memory between NUM_REQ requesters, typically the data ports of the two cores in the dual-core build.
- Uses round-robin arbitration and keeps one transaction outstanding at a time.
- Each requester sees a valid/ready request channel and a single-cycle response pulse.
- Sits between the cores' MemWrite/ALUResult/WriteData/ReadData interfaces and the shared data memory.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; word_t when 32.
- MEM_LATENCY, 1: cycles from mem_en to valid mem_rdata, 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x ADDR_W  request address.
- req_wdata  in  NUM_REQ x DATA_W  write data.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owner.
- rsp_rdata  out  DATA_W  read data, shared by all requesters; valid only with rsp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  registered index of the current or last owner.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, wait counter=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0.
  - req_ready is forced to 0 while reset=0.
- IDLE:
  - If any req_valid, req_ready[g]=1 combinationally for the winner g, else all req_ready=0.
  - Winner g is the first set req_valid searching from rr_ptr upward, wrapping at NUM_REQ.
  - On handshake (req_valid[g] & req_ready[g]): latch g, req_we, req_addr, req_wdata; rr_ptr <= (g+1) mod NUM_REQ; go to ISSUE.
- ISSUE (exactly 1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched copies; load wait counter with MEM_LATENCY; go to WAIT.
- WAIT (exactly MEM_LATENCY cycles):
  - mem_en=0; counter decrements each cycle.
  - In the final WAIT cycle (counter==1), capture mem_rdata into rsp_rdata if read; capture 0 if write. Then go to RESP.
- RESP (1 cycle): rsp_valid[owner]=1, all other rsp_valid bits 0; go to IDLE.
- Latency:
  - Handshake in cycle T -> mem_en in T+1 -> rsp_valid in T+2+MEM_LATENCY.
  - Next handshake no earlier than T+3+MEM_LATENCY.
- req_ready is 0 in ISSUE, WAIT and RESP. Requesters must hold valid and payload until ready (standard valid/ready). Deasserting valid before the handshake is legal: no transaction occurs.
- No rsp_ready: a requester must accept rsp_valid in the cycle it is asserted.
- Writes are acknowledged with rsp_valid and rsp_rdata=0.
- Simultaneous requests: exactly one is granted per IDLE cycle. The loser stays pending and wins the next IDLE cycle if rr_ptr now points to it or past the winner.
- Single requester: granted back to back; rr_ptr wraps, so no starvation.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: the in-flight transaction is abandoned. mem_en and rsp_valid drop asynchronously and no response is issued afterwards.
- All outputs except req_ready are registered.

Decomposition:
- Add to types_pkg:
  - arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - word_t reused for data.
  - Parameter-independent constant ARB_MAX_REQ=8.
- One sub-module: rr_arbiter.
  - Parameter NUM_REQ; combinational.
  - Inputs req vector and ptr; outputs one-hot gnt and gnt_idx.
  - Instantiated in mem_arbiter, which owns rr_ptr, the FSM and the latches.

Test Plan:
- Single read, MEM_LATENCY=1: req0 read addr 0x10, memory returns 0xDEADBEEF.
  - Required: req_ready[0] in cycle T, mem_en=1/mem_we=0/mem_addr=0x10 in T+1.
  - Required: rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF in T+3.
- Simultaneous requests after reset: req0 write 0x20=0x11, req1 write 0x24=0x22 held valid.
  - Required: req0 granted first (rr_ptr=0), req1 granted at T+4.
  - Required: mem writes occur in that order; rsp_valid 01 then 10.
- Fairness: both requesters continuously valid for 8 transactions.
  - Required: grants alternate 0,1,0,1,...; each requester gets exactly 4.
- MEM_LATENCY=3: req1 read addr 0x40, memory returns 0xCAFE0001.
  - Required: rsp_valid=2'b10 at T+5; busy high for 5 cycles; req_ready stays 0 throughout.
- Reset mid-WAIT: assert reset=0 during WAIT of a read.
  - Required: mem_en, rsp_valid and busy are 0 immediately.
  - Required: after release, no stale rsp_valid; the next grant goes to req0 (rr_ptr=0).
- Valid withdrawn: req1 asserts valid for 1 cycle while the arbiter is busy, then drops it.
  - Required: no handshake and no mem_en for req1.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the memory-side blocks: data word, arbiter FSM state, requester limit.
// Pure declarations; no latency or flow control of its own.
package types_pkg;

  localparam int ARB_MAX_REQ = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from ptr, wrapping at NUM_REQ.
// Purely combinational (zero latency); no backpressure, gnt is one-hot or zero.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory among NUM_REQ requesters, one transaction in flight.
// Handshake T -> mem_en T+1 -> rsp_valid T+2+MEM_LATENCY; req_ready held low while busy.
module mem_arbiter
  import types_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int         IDX_W = $clog2(NUM_REQ);
  localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_param
    $error("mem_arbiter: NUM_REQ must be 2..8 and MEM_LATENCY 1..15");
  end

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic               lat_we;
  logic [3:0]         wait_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  // Only path from inputs to outputs; gated by reset so nothing is accepted while held.
  assign req_ready = (state == IDLE && reset) ? win_gnt : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_ready) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= '0;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (|req_ready) begin
            grant_id  <= win_idx;
            rr_ptr    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            lat_we    <= req_we[win_idx];
            mem_en    <= 1'b1;
            mem_we    <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx];
            mem_wdata <= req_wdata[win_idx];
          end
        end
        ISSUE: wait_cnt <= LAT;
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          // Response is registered here so it lands exactly in the RESP cycle.
          if (wait_cnt == 4'd1) begin
            rsp_rdata <= lat_we ? '0 : mem_rdata;
            rsp_valid <= NUM_REQ'(1) << grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;
  import types_pkg::*;

  localparam int N  = 3;
  localparam int L  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  word_t                  rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]          mem_addr;
  logic                   mem_en, mem_we, busy;
  logic [IW-1:0]          grant_id;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; bit wd; } req_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mexp_t;
  typedef struct { int cyc; int own; logic [31:0] data; } rexp_t;

  req_t  sq[N][$];
  mexp_t mq[$];
  rexp_t rq[$];
  word_t pmem[logic [31:0]];
  word_t mmem[logic [31:0]];
  word_t pipe[L];

  int cyc = 0, checks = 0, failures = 0;
  int ptr = 0, free_at = 0, busy_from = 0, own = 0, first_hs = -1;
  int hcnt[N] = '{default: 0};
  logic [N-1:0] hs, cur_wd, ev, erdy;
  bit em, er;
  int g, j;
  mexp_t mx, mnew;
  rexp_t rx, rnew;
  req_t  drv_e;

  function automatic word_t dflt(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function word_t prd(logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : dflt(a);
  endfunction
  function word_t mread(logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(int i, logic we, logic [31:0] a, logic [31:0] d, bit wd);
    req_t e;
    e.we = we; e.addr = a; e.wdata = d; e.wd = wd;
    sq[i].push_back(e);
  endtask

  function automatic int pending();
    int s = mq.size() + rq.size();
    for (int i = 0; i < N; i++) s += sq[i].size();
    return s;
  endfunction

  task automatic drain();
    int t = 0;
    while ((pending() > 0 || req_valid != '0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_done", (t < 3000), 1);
    repeat (2) @(posedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: reads return data exactly L cycles after mem_en, junk otherwise.
  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_en && !mem_we) ? prd(mem_addr) : word_t'($urandom);
    if (mem_en && mem_we) pmem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = pipe[L-1];

  // Requester drivers: hold each request until handshake; withdraw-type requests last one cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          req_valid[i] = 1'b0;
        end else begin
          if (req_valid[i] && (hs[i] || cur_wd[i])) req_valid[i] = 1'b0;
          if (!req_valid[i] && sq[i].size() > 0) begin
            drv_e        = sq[i].pop_front();
            req_valid[i] = 1'b1;
            req_we[i]    = drv_e.we;
            req_addr[i]  = drv_e.addr;
            req_wdata[i] = drv_e.wdata;
            cur_wd[i]    = drv_e.wd;
          end
        end
      end
    end
  end

  // Monitor + reference model: arbiter free 3+L cycles after a grant, rotating priority.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs = '0;
    end else begin
      em = (mq.size() > 0) && (mq[0].cyc == cyc);
      chk("mem_en", mem_en, em);
      if (em) begin
        mx = mq.pop_front();
        if (mem_en) begin
          chk("mem_we", mem_we, mx.we);
          chk("mem_addr", mem_addr, mx.addr);
          if (mx.we) chk("mem_wdata", mem_wdata, mx.wdata);
        end
      end
      er = (rq.size() > 0) && (rq[0].cyc == cyc);
      ev = '0;
      if (er) begin
        rx = rq.pop_front();
        ev[IW'(rx.own)] = 1'b1;
      end
      chk("rsp_valid", rsp_valid, ev);
      if (er) chk("rsp_rdata", rsp_rdata, rx.data);
      chk("busy", busy, (cyc >= busy_from && cyc < free_at));
      if (cyc >= busy_from && cyc < free_at) chk("grant_id", grant_id, own);

      g = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (g < 0 && req_valid[IW'(j)]) g = j;
        end
      end
      erdy = '0;
      if (g >= 0) erdy[IW'(g)] = 1'b1;
      chk("req_ready", req_ready, erdy);
      if (g >= 0) begin
        mnew.cyc   = cyc + 1;
        mnew.we    = req_we[IW'(g)];
        mnew.addr  = req_addr[IW'(g)];
        mnew.wdata = req_wdata[IW'(g)];
        mq.push_back(mnew);
        rnew.cyc = cyc + 2 + L;
        rnew.own = g;
        if (mnew.we) begin
          mmem[mnew.addr] = mnew.wdata;
          rnew.data = '0;
        end else begin
          rnew.data = mread(mnew.addr);
        end
        rq.push_back(rnew);
        ptr       = (g + 1) % N;
        own       = g;
        busy_from = cyc + 1;
        free_at   = cyc + 3 + L;
      end

      hs = req_valid & req_ready;
      for (int k = 0; k < N; k++) begin
        if (hs[k]) begin
          hcnt[k]++;
          if (first_hs < 0) first_hs = k;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, t, r;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    hs        = '0;
    cur_wd    = '0;
    pmem[32'h10] = 32'hDEAD_BEEF; mmem[32'h10] = 32'hDEAD_BEEF;
    pmem[32'h40] = 32'hCAFE_0001; mmem[32'h40] = 32'hCAFE_0001;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // Simultaneous writes straight after reset: req0 first, then req1.
    push(0, 1'b1, 32'h20, 32'h11, 1'b0);
    push(1, 1'b1, 32'h24, 32'h22, 1'b0);
    drain();
    push(0, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
    push(1, 1'b0, 32'h40, 32'h0, 1'b0);
    drain();
    push(2, 1'b0, 32'h20, 32'h0, 1'b0);
    drain();

    // Fairness: two requesters continuously valid for 8 transactions.
    h0 = hcnt[0];
    h1 = hcnt[1];
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 1'b0);
      push(1, 1'b1, 32'h110 + 32'(4 * k), $urandom, 1'b0);
    end
    drain();
    chk("fair_req0", hcnt[0] - h0, 4);
    chk("fair_req1", hcnt[1] - h1, 4);

    // Valid withdrawn while busy: no handshake for req1.
    push(0, 1'b0, 32'h104, 32'h0, 1'b0);
    t = 0;
    while (!busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_seen", busy, 1);
    h1 = hcnt[1];
    push(1, 1'b0, 32'h108, 32'h0, 1'b1);
    drain();
    chk("withdraw_no_hs", hcnt[1] - h1, 0);

    // Random traffic.
    repeat (400) begin
      @(posedge clk);
      #2;
      r = $urandom_range(N - 1);
      if ($urandom_range(2) == 0 && sq[r].size() < 2)
        push(r, 1'($urandom_range(1)), 32'h100 + 32'(4 * $urandom_range(7)), $urandom,
             $urandom_range(9) == 0);
    end
    drain();

    // Reset during WAIT of a read owned by req0.
    push(0, 1'b0, 32'h10, 32'h0, 1'b0);
    t = 0;
    while (!mem_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mem_en_seen", mem_en, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    mq.delete();
    rq.delete();
    for (int i = 0; i < N; i++) sq[i].delete();
    ptr      = 0;
    free_at  = 0;
    first_hs = -1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(1, 1'b0, 32'h40, 32'h0, 1'b0);
    push(0, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
    chk("first_after_reset", first_hs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
